// File: rtl/eth_pdu_session.sv
// rtl/eth_pdu_session.sv - segments byte bursts into PDUs, queues descriptors, injects command responses
// Optional feature macro: ETH_SESSION_RSP_PRIO_EN (pending responses preempt queued data frames).
module eth_pdu_session #(
    parameter int PDU_SIZE = 1472,
    parameter int ADDR_W   = 13,
    parameter int DESC_W   = 2,
    parameter int LEN_W    = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic             i_din,
    input  logic [7:0]       i_data,
    output logic             o_full,
    input  logic [15:0]      i_cmd,
    input  logic             i_cmd_finish,
    input  logic [15:0]      i_cmd_finish_code,
    output logic             o_trig_send,
    output logic [LEN_W-1:0] o_data_length,
    output logic [7:0]       o_pck_ident,
    output logic [7:0]       o_pck_idx,
    output logic             o_pck_last,
    output logic [7:0]       o_cur_byte,
    input  logic             i_feed_next_byte,
    input  logic             i_send_over
);
    localparam int DEPTH     = 1 << DESC_W;
    localparam int BUF_BYTES = 1 << ADDR_W;
    localparam logic [LEN_W-1:0] PDU_LEN  = LEN_W'(PDU_SIZE);
    localparam logic [LEN_W-1:0] LAST_POS = LEN_W'(PDU_SIZE - 1);
    localparam logic [LEN_W-1:0] RSP_LEN  = LEN_W'(6);

    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_TRIG_DATA = 6'b000010,
        S_PREP_RSP  = 6'b000100,
        S_TRIG_RSP  = 6'b001000,
        S_SENDING   = 6'b010000,
        S_DONE      = 6'b100000
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem [BUF_BYTES];
    logic [7:0]        rd_data_q;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_raddr;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0]  frag_len_q, frag_len_d, rem_q, rem_d;
    logic              storing_q, storing_d;
    logic [7:0]        ident_q, ident_d, idx_q, idx_d;
    logic [LEN_W-1:0]  d_len_q [DEPTH];
    logic [7:0]        d_ident_q [DEPTH];
    logic [7:0]        d_idx_q [DEPTH];
    logic [DEPTH-1:0]  d_last_q;
    logic [DESC_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [DESC_W:0]   desc_cnt_q, desc_cnt_d;
    logic              full_q, full_d;
    logic              wren, push, pop, push_last, start_data, feed_data, rsp_clr;
    logic [LEN_W-1:0]  push_len;
    logic [2:0]        cf_sync_q, cf_sync_d;
    logic              rsp_pend_q, rsp_pend_d;
    logic [47:0]       rsp_q, rsp_d;
    logic [2:0]        rsp_idx_q, rsp_idx_d;
    logic              is_rsp_q, is_rsp_d, rd_valid_q, rd_valid_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        oident_q, oident_d, oidx_q, oidx_d;
    logic              olast_q, olast_d;
    logic [7:0]        rsp_byte;

    // Write side: fragment segmentation and burst close.
    always_comb begin
        wren       = i_wr & i_din & ~full_q;
        push       = 1'b0;
        push_len   = frag_len_q;
        push_last  = 1'b0;
        wr_addr_d  = wr_addr_q;
        frag_len_d = frag_len_q;
        idx_d      = idx_q;
        ident_d    = ident_q;
        storing_d  = storing_q | i_wr;
        if (wren) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            if (frag_len_q == LAST_POS) begin
                push       = 1'b1;
                push_len   = PDU_LEN;
                frag_len_d = '0;
                idx_d      = idx_q + 8'd1;
            end else begin
                frag_len_d = frag_len_q + LEN_W'(1);
            end
        end
        if (!i_wr && storing_q) begin
            push       = (frag_len_q != '0);
            push_last  = 1'b1;
            frag_len_d = '0;
            idx_d      = '0;
            ident_d    = ident_q + 8'd1;
            storing_d  = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        start_data = 1'b0;
        feed_data  = 1'b0;
        rsp_clr    = 1'b0;
        rd_en      = 1'b0;
        rd_raddr   = rd_addr_q;
        rd_addr_d  = rd_addr_q;
        rem_d      = rem_q;
        rsp_d      = rsp_q;
        rsp_idx_d  = rsp_idx_q;
        is_rsp_d   = is_rsp_q;
        rd_valid_d = rd_valid_q;
        len_d      = len_q;
        oident_d   = oident_q;
        oidx_d     = oidx_q;
        olast_d    = olast_q;
        case (state_q)
            S_IDLE: begin
`ifdef ETH_SESSION_RSP_PRIO_EN
                if (rsp_pend_q) state_d = S_PREP_RSP;
                else if (desc_cnt_q != '0) start_data = 1'b1;
`else
                if (desc_cnt_q != '0) start_data = 1'b1;
                else if (rsp_pend_q) state_d = S_PREP_RSP;
`endif
            end
            S_TRIG_DATA: state_d = S_SENDING;
            S_PREP_RSP: begin
                rsp_d     = {i_cmd, ~i_cmd, i_cmd_finish_code};
                rsp_idx_d = '0;
                is_rsp_d  = 1'b1;
                len_d     = RSP_LEN;
                oident_d  = 8'hFF;
                oidx_d    = 8'hFF;
                olast_d   = 1'b1;
                state_d   = S_TRIG_RSP;
            end
            S_TRIG_RSP: begin
                rsp_clr = 1'b1;
                state_d = S_SENDING;
            end
            S_SENDING: if (i_send_over) state_d = S_DONE;
            S_DONE: begin
                pop     = ~is_rsp_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are loaded on entry so they are already valid during the trig cycle.
        if (start_data) begin
            state_d    = S_TRIG_DATA;
            len_d      = d_len_q[head_q];
            oident_d   = d_ident_q[head_q];
            oidx_d     = d_idx_q[head_q];
            olast_d    = d_last_q[head_q];
            rem_d      = d_len_q[head_q];
            is_rsp_d   = 1'b0;
            rd_valid_d = 1'b1;
            rd_en      = 1'b1;
        end
        if (i_feed_next_byte && (state_q == S_TRIG_DATA || state_q == S_TRIG_RSP || state_q == S_SENDING)) begin
            if (is_rsp_q) begin
                if (rsp_idx_q != 3'd5) rsp_idx_d = rsp_idx_q + 3'd1;
            end else if (rem_q != '0) begin
                feed_data = 1'b1;
                rem_d     = rem_q - LEN_W'(1);
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                rd_raddr  = rd_addr_d;
                rd_en     = 1'b1;
            end
        end
    end

    always_comb begin
        tail_d     = push ? tail_q + DESC_W'(1) : tail_q;
        head_d     = pop ? head_q + DESC_W'(1) : head_q;
        desc_cnt_d = desc_cnt_q;
        if (push && !pop) desc_cnt_d = desc_cnt_q + (DESC_W+1)'(1);
        if (!push && pop) desc_cnt_d = desc_cnt_q - (DESC_W+1)'(1);
        byte_cnt_d = byte_cnt_q;
        if (wren && !feed_data) byte_cnt_d = byte_cnt_q + (ADDR_W+1)'(1);
        if (!wren && feed_data) byte_cnt_d = byte_cnt_q - (ADDR_W+1)'(1);
        // An open fragment reserves the slot its close-push will need.
        full_d = ((int'(desc_cnt_d) + int'(frag_len_d != '0)) == DEPTH) || (int'(byte_cnt_d) == BUF_BYTES);
        cf_sync_d  = {cf_sync_q[1:0], i_cmd_finish};
        rsp_pend_d = (rsp_pend_q & ~rsp_clr) | (cf_sync_q[1] & ~cf_sync_q[2]);
        case (rsp_idx_q)
            3'd0:    rsp_byte = rsp_q[47:40];
            3'd1:    rsp_byte = rsp_q[39:32];
            3'd2:    rsp_byte = rsp_q[31:24];
            3'd3:    rsp_byte = rsp_q[23:16];
            3'd4:    rsp_byte = rsp_q[15:8];
            default: rsp_byte = rsp_q[7:0];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            byte_cnt_q <= '0;
            frag_len_q <= '0;
            rem_q      <= '0;
            storing_q  <= 1'b0;
            ident_q    <= '0;
            idx_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            desc_cnt_q <= '0;
            full_q     <= 1'b0;
            cf_sync_q  <= '0;
            rsp_pend_q <= 1'b0;
            rsp_q      <= '0;
            rsp_idx_q  <= '0;
            is_rsp_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            len_q      <= '0;
            oident_q   <= '0;
            oidx_q     <= '0;
            olast_q    <= 1'b0;
            d_last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_len_q[i]   <= '0;
                d_ident_q[i] <= '0;
                d_idx_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            byte_cnt_q <= byte_cnt_d;
            frag_len_q <= frag_len_d;
            rem_q      <= rem_d;
            storing_q  <= storing_d;
            ident_q    <= ident_d;
            idx_q      <= idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            desc_cnt_q <= desc_cnt_d;
            full_q     <= full_d;
            cf_sync_q  <= cf_sync_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_q      <= rsp_d;
            rsp_idx_q  <= rsp_idx_d;
            is_rsp_q   <= is_rsp_d;
            rd_valid_q <= rd_valid_d;
            len_q      <= len_d;
            oident_q   <= oident_d;
            oidx_q     <= oidx_d;
            olast_q    <= olast_d;
            if (push) begin
                d_len_q[tail_q]   <= push_len;
                d_ident_q[tail_q] <= ident_q;
                d_idx_q[tail_q]   <= idx_q;
                d_last_q[tail_q]  <= push_last;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wren) mem[wr_addr_q] <= i_data;
        if (rd_en) rd_data_q <= mem[rd_raddr];
    end

    assign o_full        = full_q;
    assign o_trig_send   = (state_q == S_TRIG_DATA) || (state_q == S_TRIG_RSP);
    assign o_data_length = len_q;
    assign o_pck_ident   = oident_q;
    assign o_pck_idx     = oidx_q;
    assign o_pck_last    = olast_q;
    assign o_cur_byte    = is_rsp_q ? rsp_byte : (rd_valid_q ? rd_data_q : 8'h00);
endmodule

// File: tb/tb_eth_pdu_session.sv
// tb/tb_eth_pdu_session.sv - directed scoreboard bench for eth_pdu_session (PDU_SIZE=4, DESC_W=2)
module tb_eth_pdu_session;
    localparam int PDU = 4;

    typedef struct packed {
        logic [10:0] len;
        logic [7:0]  ident;
        logic [7:0]  idx;
        logic        last;
        logic [63:0] bytes;
    } frame_t;

    logic        clk, i_rst_n, i_wr, i_din, o_full, i_cmd_finish, o_trig_send;
    logic [7:0]  i_data, o_pck_ident, o_pck_idx, o_cur_byte;
    logic [15:0] i_cmd, i_cmd_finish_code;
    logic [10:0] o_data_length;
    logic        o_pck_last, i_feed_next_byte, i_send_over;

    int tests = 0, fails = 0, cyc = 0, done_cyc = 0, trig_seen = 0;
    int acc, tmark;
    logic sink_hold = 1'b0, sink_abort = 1'b0, in_frame = 1'b0;
    frame_t exp_q[$];
    frame_t sf;
    int m_frag = 0;
    logic [7:0]  m_idx = 8'd0, m_ident = 8'd0;
    logic [63:0] m_bytes = '0;

    eth_pdu_session #(.PDU_SIZE(PDU), .ADDR_W(6), .DESC_W(2), .LEN_W(11)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_din(i_din), .i_data(i_data),
        .o_full(o_full), .i_cmd(i_cmd), .i_cmd_finish(i_cmd_finish),
        .i_cmd_finish_code(i_cmd_finish_code), .o_trig_send(o_trig_send),
        .o_data_length(o_data_length), .o_pck_ident(o_pck_ident), .o_pck_idx(o_pck_idx),
        .o_pck_last(o_pck_last), .o_cur_byte(o_cur_byte),
        .i_feed_next_byte(i_feed_next_byte), .i_send_over(i_send_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int len, input logic last);
        frame_t f;
        f.len   = 11'(len);
        f.ident = m_ident;
        f.idx   = m_idx;
        f.last  = last;
        f.bytes = m_bytes;
        exp_q.push_back(f);
        m_idx   = m_idx + 8'd1;
        m_frag  = 0;
        m_bytes = '0;
    endtask

    function automatic frame_t rsp_frame(input logic [47:0] r);
        frame_t f;
        f.len   = 11'd6;
        f.ident = 8'hFF;
        f.idx   = 8'hFF;
        f.last  = 1'b1;
        f.bytes = '0;
        for (int k = 0; k < 6; k++) f.bytes[8*k +: 8] = r[47-8*k -: 8];
        return f;
    endfunction

    // Bytes refused by o_full never enter the expected stream.
    task automatic write_burst(input int n, input logic [7:0] start, output int accepted);
        accepted = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_wr = 1'b1; i_din = 1'b1; i_data = 8'(start + k);
            if (!o_full) begin
                m_bytes[8*m_frag +: 8] = i_data;
                m_frag++;
                accepted++;
                if (m_frag == PDU) push_frame(PDU, 1'b0);
            end
        end
        @(negedge clk);
        i_wr = 1'b0; i_din = 1'b0;
        if (m_frag != 0) push_frame(m_frag, 1'b1);
        m_ident = m_ident + 8'd1;
        m_idx   = 8'd0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || in_frame) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(exp_q.size() == 0 && !in_frame), 64'd1);
    endtask

    // eth_commu stand-in: pops the expected frame on each trigger and consumes its bytes.
    initial begin
        i_feed_next_byte = 1'b0;
        i_send_over = 1'b0;
        forever begin
            @(negedge clk);
            if (i_rst_n && o_trig_send) begin
                trig_seen++;
                in_frame = 1'b1;
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_frame: observed len %0h ident %0h, expected no frame", o_data_length, o_pck_ident);
                end
                if (exp_q.size() != 0) begin
                    sf = exp_q.pop_front();
                    check("frame_hdr", {o_data_length, o_pck_ident, o_pck_idx, o_pck_last},
                          {sf.len, sf.ident, sf.idx, sf.last});
                    while (sink_hold && !sink_abort) @(negedge clk);
                    if (!sink_abort) begin
                        for (int k = 0; k < int'(sf.len); k++) begin
                            check("frame_byte", o_cur_byte, sf.bytes[8*k +: 8]);
                            i_feed_next_byte = 1'b1;
                            @(negedge clk);
                        end
                        i_feed_next_byte = 1'b0;
                        i_send_over = 1'b1;
                        @(negedge clk);
                        i_send_over = 1'b0;
                        done_cyc = cyc;
                    end
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        i_rst_n = 1'b0; i_wr = 1'b0; i_din = 1'b0; i_data = 8'h00;
        i_cmd = 16'h0; i_cmd_finish = 1'b0; i_cmd_finish_code = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {o_trig_send, o_data_length, o_pck_ident, o_pck_idx, o_pck_last, o_cur_byte, o_full}, 64'd0);
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_trig", trig_seen, 0);

        // 10 bytes -> 4,4,2 with last on the remainder
        write_burst(10, 8'h00, acc);
        check("t1_accepted", acc, 10);
        wait_drain("t1_drain");

        // exact PDU boundary: no extra frame, last stays 0
        write_burst(8, 8'h40, acc);
        wait_drain("t2_drain");
        check("t2_frames", trig_seen, 5);

        // ring fills: 3 descriptors plus an open fragment
        sink_hold = 1'b1;
        write_burst(16, 8'h80, acc);
        check("t3_accepted", acc, 13);
        check("t3_full", o_full, 1'b1);
        sink_hold = 1'b0;
        tmark = 0;
        while (o_full && tmark < 200) begin
            @(negedge clk);
            tmark++;
        end
        check("t3_full_release", o_full, 1'b0);
        check("t3_full_drop_timing", cyc, done_cyc + 1);
        wait_drain("t3_drain");

        // command response from IDLE
        i_cmd = 16'h1234; i_cmd_finish_code = 16'h0001;
        exp_q.push_back(rsp_frame(48'h1234_EDCB_0001));
        tmark = trig_seen;
        i_cmd_finish = 1'b1;
        wait_drain("t4_drain");
        i_cmd_finish = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_single_rsp", trig_seen, tmark + 1);

        // response requested while a data frame is in flight with two more queued
        sink_hold = 1'b1;
        write_burst(12, 8'hA0, acc);
        tmark = 0;
        while (!in_frame && tmark < 100) begin
            @(negedge clk);
            tmark++;
        end
        check("t5_frame_started", in_frame, 1'b1);
        i_cmd = 16'hBEEF; i_cmd_finish_code = 16'h5A5A;
`ifdef ETH_SESSION_RSP_PRIO_EN
        exp_q.push_front(rsp_frame(48'hBEEF_4110_5A5A));
`else
        exp_q.push_back(rsp_frame(48'hBEEF_4110_5A5A));
`endif
        i_cmd_finish = 1'b1;
        repeat (6) @(negedge clk);
        sink_hold = 1'b0;
        wait_drain("t5_drain");
        i_cmd_finish = 1'b0;

        // reset while a frame is being sent
        sink_hold = 1'b1;
        write_burst(4, 8'hC0, acc);
        tmark = 0;
        while (!in_frame && tmark < 100) begin
            @(negedge clk);
            tmark++;
        end
        repeat (3) @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_outputs", {o_trig_send, o_data_length, o_pck_ident, o_pck_idx, o_pck_last, o_cur_byte, o_full}, 64'd0);
        sink_abort = 1'b1;
        tmark = 0;
        while (in_frame && tmark < 20) begin
            @(negedge clk);
            tmark++;
        end
        exp_q.delete();
        sink_abort = 1'b0;
        sink_hold = 1'b0;
        m_ident = 8'd0; m_idx = 8'd0; m_frag = 0; m_bytes = '0;
        i_rst_n = 1'b1;
        tmark = trig_seen;
        repeat (20) @(negedge clk);
        check("t6_no_frame_after_reset", trig_seen, tmark);
        write_burst(3, 8'hD0, acc);
        wait_drain("t6_post_reset_drain");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
